xadc_poller: RTL and testbench

Parametrised XADC DRP controller that autonomously polls a list of `NCH` status registers into a result cache while still serving host DRP read/write requests. It sits between the host register bus (same `din`/`dout` packing as earlier XADC wrappers) and an XADC primitive instantiated by the parent. The DRP port is exposed so that the block can be simulated against a DRP model.

---
 rtl/xadc_poller_if.sv | 12 +
 rtl/xadc_poller.sv | 217 +++++++++++++++++++++
 tb/tb_xadc_poller.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_poller_if.sv
// DRP request/response bundle between xadc_poller and an XADC primitive or DRP model.
interface xadc_poller_if;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (output drp_den, drp_dwe, drp_daddr, drp_di, input drp_do, drp_drdy);
    modport slave  (input drp_den, drp_dwe, drp_daddr, drp_di, output drp_do, drp_drdy);
endinterface

// File: rtl/xadc_poller.sv
// XADC DRP poller: caches NCH status registers while serving host DRP requests.
// Optional per-channel threshold alarms are built when XADC_POLLER_ALARM_EN is defined.
module xadc_poller #(
    parameter int unsigned      NCH      = 4,
    parameter logic [7*NCH-1:0] CH_ADDRS = {7'h06, 7'h02, 7'h01, 7'h00},
    parameter int unsigned      PERIOD   = 1000,
    parameter int unsigned      TIMEOUT  = 255
`ifdef XADC_POLLER_ALARM_EN
    ,
    parameter logic [16*NCH-1:0] ALARM_HI = {NCH{16'hFFFF}},
    parameter logic [16*NCH-1:0] ALARM_LO = '0
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write,
    input  logic [23:0]       din,
    output logic [17:0]       dout,
    output logic [16*NCH-1:0] results,
    output logic [NCH-1:0]    valid,
    output logic              timeout,
`ifdef XADC_POLLER_ALARM_EN
    output logic [NCH-1:0]    alarm,
`endif
    xadc_poller_if.master     drp
);

    localparam int unsigned   IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);
    localparam logic [7:0]    TO_LIM   = 8'(TIMEOUT);
    localparam logic [20:0]   PER_LD   = 21'(PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_HOST, S_POLL, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [23:0]       preq_q, preq_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [20:0]       timer_q, timer_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              den_q, den_d;
    logic              dwe_q, dwe_d;
    logic [6:0]        daddr_q, daddr_d;
    logic [15:0]       di_q, di_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              ovr_q, ovr_d;
    logic [16*NCH-1:0] results_q, results_d;
    logic [NCH-1:0]    valid_q, valid_d;
    logic              tout_q, tout_d;

    logic        accept;
    logic [23:0] req;

    // A write is only buffered when the single pending slot is free and no host transfer is live.
    assign accept = write && !pend_q && (state_q != S_HOST);
    assign req    = pend_q ? preq_q : din;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        preq_d    = preq_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        wcnt_d    = wcnt_q;
        den_d     = 1'b0;
        dwe_d     = dwe_q;
        daddr_d   = daddr_q;
        di_d      = di_q;
        rdata_d   = rdata_q;
        ovr_d     = ovr_q;
        results_d = results_q;
        valid_d   = valid_q;
        tout_d    = tout_q;

        if (write) begin
            if (accept) begin
                pend_d = 1'b1;
                preq_d = din;
                ovr_d  = 1'b0;
            end else begin
                ovr_d  = 1'b1;
            end
        end

        if (state_q != S_WAIT && timer_q != '0) begin
            timer_d = timer_q - 21'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                // A write arriving this cycle goes straight out so drp_den follows it by one clock.
                if (pend_q || accept) begin
                    state_d = S_HOST;
                    pend_d  = 1'b0;
                    den_d   = 1'b1;
                    dwe_d   = req[23];
                    daddr_d = req[22:16];
                    di_d    = req[15:0];
                    wcnt_d  = 8'd1;
                end else if (timer_q == '0) begin
                    state_d = S_POLL;
                    den_d   = 1'b1;
                    dwe_d   = 1'b0;
                    daddr_d = CH_ADDRS[7*idx_q +: 7];
                    di_d    = '0;
                    wcnt_d  = 8'd1;
                end
            end
            S_HOST: begin
                if (drp.drp_drdy) begin
                    rdata_d = drp.drp_do;
                    state_d = S_IDLE;
                end else if (wcnt_q == TO_LIM) begin
                    rdata_d = '1;
                    tout_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            S_POLL: begin
                if (drp.drp_drdy || wcnt_q == TO_LIM) begin
                    if (drp.drp_drdy) begin
                        results_d[16*idx_q +: 16] = drp.drp_do;
                        valid_d[idx_q]            = 1'b1;
                    end else begin
                        tout_d = 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                timer_d = PER_LD;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pend_q    <= 1'b0;
            preq_q    <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            wcnt_q    <= '0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
            rdata_q   <= '0;
            ovr_q     <= 1'b0;
            results_q <= '0;
            valid_q   <= '0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            preq_q    <= preq_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            wcnt_q    <= wcnt_d;
            den_q     <= den_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            di_q      <= di_d;
            rdata_q   <= rdata_d;
            ovr_q     <= ovr_d;
            results_q <= results_d;
            valid_q   <= valid_d;
            tout_q    <= tout_d;
        end
    end

`ifdef XADC_POLLER_ALARM_EN
    logic [NCH-1:0] alarm_q, alarm_d;

    // Compared against the stored result, so the flag lags the cache update by one clock.
    always_comb begin
        alarm_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            alarm_d[i] = valid_q[i] &&
                         ((results_q[16*i +: 16] > ALARM_HI[16*i +: 16]) ||
                          (results_q[16*i +: 16] < ALARM_LO[16*i +: 16]));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alarm_q <= '0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

    assign dout          = {ovr_q, (pend_q || state_q == S_HOST), rdata_q};
    assign results       = results_q;
    assign valid         = valid_q;
    assign timeout       = tout_q;
    assign drp.drp_den   = den_q;
    assign drp.drp_dwe   = dwe_q;
    assign drp.drp_daddr = daddr_q;
    assign drp.drp_di    = di_q;

endmodule

// File: tb/tb_xadc_poller.sv
// Randomized bench for xadc_poller against a fixed-latency DRP memory model.
`timescale 1ns/1ps
module tb_xadc_poller;

    localparam int unsigned      NCH     = 4;
    localparam int unsigned      PERIOD  = 10;
    localparam int unsigned      TIMEOUT = 8;
    localparam int unsigned      LAT     = 4;
    localparam logic [7*NCH-1:0] ADDRS   = {7'h06, 7'h02, 7'h01, 7'h00};

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              write   = 1'b0;
    logic [23:0]       din     = '0;
    logic [17:0]       dout;
    logic [16*NCH-1:0] results;
    logic [NCH-1:0]    valid;
    logic              timeout;
`ifdef XADC_POLLER_ALARM_EN
    logic [NCH-1:0]    alarm;
`endif

    xadc_poller_if drp();

    xadc_poller #(
        .NCH(NCH), .CH_ADDRS(ADDRS), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
`ifdef XADC_POLLER_ALARM_EN
        , .ALARM_HI({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000}), .ALARM_LO({NCH{16'h0000}})
`endif
    ) dut (
        .clock(clock), .reset_n(reset_n), .write(write), .din(din), .dout(dout),
        .results(results), .valid(valid), .timeout(timeout),
`ifdef XADC_POLLER_ALARM_EN
        .alarm(alarm),
`endif
        .drp(drp)
    );

    always #5 clock = ~clock;

    logic [6:0]  ref_addr [NCH] = '{7'h00, 7'h01, 7'h02, 7'h06};
    logic [15:0] mem [128];
    bit          respond = 1'b1;
    int unsigned cyc = 0, rdy_count = 0, last_rdy_cyc = 0;
    logic [6:0]  last_rdy_addr = '0;
    logic        last_rdy_we = 1'b0;
    logic [6:0]  q_addr [$];
    logic        q_we [$];
    logic [15:0] q_di [$];
    int unsigned q_cyc [$];
    int          errors = 0, checks = 0;

    // DRP slave: answers LAT cycles after drp_den; writes echo the written data.
    initial begin : drp_model
        bit          pending = 1'b0;
        int unsigned remain = 0;
        logic [6:0]  a = '0;
        logic        w = 1'b0;
        logic [15:0] d = '0;
        drp.drp_drdy = 1'b0;
        drp.drp_do   = '0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            drp.drp_drdy = 1'b0;
            if (!reset_n) pending = 1'b0;
            if (pending) begin
                remain--;
                if (remain == 0) begin
                    pending = 1'b0;
                    if (w) mem[a] = d;
                    drp.drp_do    = w ? d : mem[a];
                    drp.drp_drdy  = 1'b1;
                    rdy_count++;
                    last_rdy_addr = a;
                    last_rdy_we   = w;
                    last_rdy_cyc  = cyc;
                end
            end
            if (drp.drp_den === 1'b1) begin
                checks++;
                if (pending) begin
                    errors++;
                    $display("FAIL den_overlap: drp_den at cycle %0d with a transfer outstanding, required none", cyc);
                end
                q_addr.push_back(drp.drp_daddr);
                q_we.push_back(drp.drp_dwe);
                q_di.push_back(drp.drp_di);
                q_cyc.push_back(cyc);
                if (respond) begin
                    pending = 1'b1;
                    remain  = LAT;
                    a = drp.drp_daddr;
                    w = drp.drp_dwe;
                    d = drp.drp_di;
                end
            end
        end
    end

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clock); #2;
        end
    endtask

    task automatic wait_not_busy(input int unsigned limit, input string tag);
        for (int unsigned i = 0; i < limit; i++) begin
            if (dout[16] === 1'b0) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL %s_busy: dout[16]=%b after %0d cycles, required 0", tag, dout[16], limit);
    endtask

    task automatic wait_round_end();
        int unsigned n = rdy_count;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rdy_count > n && last_rdy_addr == ref_addr[NCH-1] && !last_rdy_we) begin
                tick(2);
                return;
            end
        end
        checks++; errors++;
        $display("FAIL round_end: no final-channel poll response in 300 cycles, required one");
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h, required 0", dout); end
        checks++; if (results !== '0) begin errors++; $display("FAIL reset_results: got %h, required 0", results); end
        checks++; if (valid !== '0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
        checks++; if (drp.drp_den !== 1'b0) begin errors++; $display("FAIL reset_den: got %b, required 0", drp.drp_den); end
    endtask

    task automatic test_poll_round();
        int unsigned base = q_addr.size();
        int unsigned rel, exp_gap;
        reset_n = 1'b1;
        rel = cyc;
        for (int i = 0; i < 200 && valid !== 4'hF; i++) tick();
        checks++; if (valid !== 4'hF) begin errors++; $display("FAIL poll_valid: got %b, required 1111", valid); end
        checks++;
        if (q_cyc[base] != rel + 1) begin
            errors++; $display("FAIL poll_first_den: cycle %0d, required %0d", q_cyc[base], rel + 1);
        end
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (q_addr[base+i] !== ref_addr[i] || q_we[base+i] !== 1'b0) begin
                errors++; $display("FAIL poll_addr%0d: addr %h we %b, required addr %h we 0", i, q_addr[base+i], q_we[base+i], ref_addr[i]);
            end
            checks++;
            if (results[16*i +: 16] !== mem[ref_addr[i]]) begin
                errors++; $display("FAIL poll_data%0d: got %h, required %h", i, results[16*i +: 16], mem[ref_addr[i]]);
            end
        end
        for (int i = 0; i < 200 && q_addr.size() < base + NCH + 1; i++) tick();
        exp_gap = PERIOD + ((NCH - 1) * (LAT + 2) + LAT + 1) + 2;
        checks++;
        if (q_addr.size() < base + NCH + 1 || q_cyc[base+NCH] - q_cyc[base] != exp_gap) begin
            errors++; $display("FAIL round_spacing: got %0d, required %0d", q_cyc[base+NCH] - q_cyc[base], exp_gap);
        end
    endtask

    task automatic test_host_read();
        logic [6:0]  a;
        logic [15:0] v;
        wait_round_end();
        mem[7'h03] = 16'hABCD;
        din = 24'h030000; write = 1'b1;
        tick();
        write = 1'b0;
        checks++;
        if (drp.drp_den !== 1'b1 || drp.drp_daddr !== 7'h03 || drp.drp_dwe !== 1'b0 || dout[16] !== 1'b1) begin
            errors++; $display("FAIL host_req: den %b addr %h dwe %b busy %b, required 1 03 0 1",
                               drp.drp_den, drp.drp_daddr, drp.drp_dwe, dout[16]);
        end
        wait_not_busy(50, "host_read");
        checks++; if (cyc != last_rdy_cyc + 1) begin errors++; $display("FAIL host_latency: busy cleared cycle %0d, required %0d", cyc, last_rdy_cyc + 1); end
        checks++; if (dout !== 18'h0ABCD) begin errors++; $display("FAIL host_dout: got %h, required 0abcd", dout); end
        repeat (3) begin
            a = 7'($urandom_range(0, 127));
            v = 16'($urandom);
            mem[a] = v;
            din = {1'b0, a, 16'($urandom)}; write = 1'b1;
            tick();
            write = 1'b0;
            wait_not_busy(100, "host_rand");
            checks++; if (dout !== {2'b00, v}) begin errors++; $display("FAIL host_rand_%h: got %h, required %h", a, dout, {2'b00, v}); end
        end
    endtask

    task automatic test_host_write_during_poll();
        int unsigned base;
        for (int i = 0; i < 200; i++) begin
            if (drp.drp_den === 1'b1 && drp.drp_dwe === 1'b0 && drp.drp_daddr === ref_addr[1]) break;
            tick();
        end
        base = q_addr.size();
        din = 24'hC21234; write = 1'b1;
        tick();
        write = 1'b0;
        checks++; if (dout[16] !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b, required 1", dout[16]); end
        wait_not_busy(100, "wr_poll");
        for (int i = 0; i < 100 && q_addr.size() < base + 2; i++) tick();
        checks++;
        if (q_we[base] !== 1'b1 || q_addr[base] !== 7'h42 || q_di[base] !== 16'h1234) begin
            errors++; $display("FAIL wr_req: we %b addr %h di %h, required 1 42 1234", q_we[base], q_addr[base], q_di[base]);
        end
        checks++;
        if (q_cyc[base] != q_cyc[base-1] + LAT + 2) begin
            errors++; $display("FAIL wr_after_poll: den cycle %0d, required %0d", q_cyc[base], q_cyc[base-1] + LAT + 2);
        end
        checks++;
        if (q_addr[base+1] !== ref_addr[2] || q_we[base+1] !== 1'b0) begin
            errors++; $display("FAIL wr_resume: addr %h, required %h", q_addr[base+1], ref_addr[2]);
        end
        checks++; if (dout !== 18'h01234) begin errors++; $display("FAIL wr_echo: got %h, required 01234", dout); end
    endtask

    task automatic test_overrun();
        int unsigned base;
        wait_round_end();
        base = q_addr.size();
        din = {1'b0, 7'h05, 16'h0000}; write = 1'b1;
        tick();
        din = {1'b0, 7'h07, 16'h0000};
        tick();
        write = 1'b0;
        checks++; if (dout[17] !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b, required 1", dout[17]); end
        wait_not_busy(50, "ovr");
        checks++; if (dout !== {2'b10, mem[7'h05]}) begin errors++; $display("FAIL ovr_hold: got %h, required %h", dout, {2'b10, mem[7'h05]}); end
        checks++;
        if (q_addr.size() != base + 1 || q_addr[base] !== 7'h05) begin
            errors++; $display("FAIL ovr_dropped: %0d new transfers, required 1 to addr 05", q_addr.size() - base);
        end
        din = {1'b0, 7'h09, 16'h0000}; write = 1'b1;
        tick();
        write = 1'b0;
        checks++; if (dout[17] !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b, required 0", dout[17]); end
        wait_not_busy(100, "ovr_clr");
    endtask

`ifdef XADC_POLLER_ALARM_EN
    task automatic test_alarm();
        wait_round_end();
        mem[7'h00] = 16'h9000;
        wait_round_end();
        checks++; if (alarm !== 4'b0001) begin errors++; $display("FAIL alarm_set: got %b, required 0001", alarm); end
        mem[7'h00] = 16'h7000;
        wait_round_end();
        checks++; if (alarm !== 4'b0000) begin errors++; $display("FAIL alarm_clear: got %b, required 0000", alarm); end
    endtask
`endif

    task automatic test_timeout();
        int unsigned t0, el, n, k;
        logic [16*NCH-1:0] res;
        logic [NCH-1:0]    vld;
        wait_round_end();
        respond = 1'b0;
        din = 24'h110000; write = 1'b1;
        t0 = cyc;
        tick();
        write = 1'b0;
        wait_not_busy(TIMEOUT + 10, "to_host");
        el = cyc - t0;
        checks++; if (el < TIMEOUT || el > TIMEOUT + 2) begin errors++; $display("FAIL to_host_time: %0d cycles, required %0d..%0d", el, TIMEOUT, TIMEOUT + 2); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b, required 1", timeout); end
        checks++; if (dout[15:0] !== 16'hFFFF) begin errors++; $display("FAIL to_host_data: got %h, required ffff", dout[15:0]); end
        res = results;
        vld = valid;
        n = q_addr.size();
        for (int i = 0; i < 400 && q_addr.size() < n + NCH + 1; i++) tick();
        k = 0;
        for (int j = 0; j < NCH; j++) if (q_addr[n] === ref_addr[j]) k = j;
        for (int j = 1; j <= NCH; j++) begin
            checks++;
            if (q_addr[n+j] !== ref_addr[(k + j) % NCH]) begin
                errors++; $display("FAIL to_poll_idx%0d: addr %h, required %h", j, q_addr[n+j], ref_addr[(k + j) % NCH]);
            end
        end
        checks++; if (results !== res || valid !== vld) begin errors++; $display("FAIL to_poll_cache: results %h valid %b, required %h %b", results, valid, res, vld); end
        respond = 1'b1;
        tick();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b, required 1", timeout); end
    endtask

    task automatic test_reset_mid();
        int unsigned base, rc;
        for (int i = 0; i < 200; i++) begin
            if (drp.drp_den === 1'b1 && drp.drp_dwe === 1'b0) break;
            tick();
        end
        tick();
        reset_n = 1'b0;
        tick(2);
        checks++;
        if (valid !== '0 || results !== '0 || timeout !== 1'b0 || dout !== '0) begin
            errors++; $display("FAIL midreset: valid %b results %h timeout %b dout %h, required all 0", valid, results, timeout, dout);
        end
        base = q_addr.size();
        reset_n = 1'b1;
        rc = cyc;
        for (int i = 0; i < 20 && q_addr.size() <= base; i++) tick();
        checks++;
        if (q_addr.size() <= base || q_addr[base] !== ref_addr[0] || q_cyc[base] != rc + 1) begin
            errors++; $display("FAIL midreset_restart: addr %h cycle %0d, required %h at %0d", q_addr[base], q_cyc[base], ref_addr[0], rc + 1);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 16'($urandom);
        test_reset();
        test_poll_round();
        test_host_read();
        test_host_write_during_poll();
        test_overrun();
`ifdef XADC_POLLER_ALARM_EN
        test_alarm();
`endif
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
